systolic_4x4_ctrl: RTL
======================

# systolic_4x4_ctrl

Sequencing controller for the 4x4 output-stationary systolic array. It accepts a job length K and then K beats of operand vectors (one A column plus one B row per beat) over a valid/ready stream. It applies the diagonal input skew, drives the array enable and accumulator clear, and drains the pipeline. It then captures the 16 accumulated results and presents them on a valid/ready result port. It sits between the LSTM datapath sequencer (operand fetch) and the array instance.

## Interface
- data_width, 8, operand element width
- acc_width, 2*data_width, accumulator/result element width
- k_width, 8, width of the job-length field (K_MAX = 2^k_width - 1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- cfg_k  in  k_width  number of operand beats K; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result handshake completes
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_a  in  4*data_width  A column, lane i = row i at [i*data_width +: data_width]
- in_b  in  4*data_width  B row, lane j = column j
- arr_en  out  1  array enable; the array advances and accumulates only when high
- arr_clr  out  1  registered clear pulse to the array reset (active-high at the array)
- arr_a_flat  out  4*data_width  skewed A lanes to the array
- arr_b_flat  out  4*data_width  skewed B lanes to the array
- arr_c_flat  in  16*acc_width  array accumulators, element r*4+c
- res_valid  out  1  result held valid
- res_ready  in  1  result consumer ready
- res_c  out  16*acc_width  captured result, same packing as arr_c_flat

## Operation
- Reset values: state IDLE; busy, done, in_ready, arr_en, arr_clr and res_valid all 0; arr_a_flat, arr_b_flat, res_c and all skew registers 0; beat and drain counters 0.
- IDLE: on start, latch cfg_k.
  - cfg_k==0 goes to RESULT with res_c=0, with no clear and no feed.
  - Otherwise go to CLEAR.
  - start while busy is ignored.
- CLEAR (1 cycle): arr_clr=1 and arr_en=0. Zero the skew lines. Go to FEED.
- FEED: in_ready=1.
  - On an accepted beat: push in_a/in_b lanes into the skew lines, arr_en=1, and increment the beat counter.
  - No beat: arr_en=0, and the skew lines and array hold (stall).
  - After beat K, go to DRAIN.
- DRAIN: in_ready=0 and arr_en=1. Push zeros into the skew lines for exactly 6 cycles (3 of skew plus 3 hops to PE(3,3)). Then go to CAPTURE.
- CAPTURE (1 cycle): arr_en=0. Register arr_c_flat into res_c. Go to RESULT.
- RESULT: res_valid=1 and res_c is stable.
  - On res_ready: done pulses in the same cycle as the handshake and the next state is IDLE.
  - If res_ready is low, hold indefinitely.
- Skew: A lane i and B lane j are delayed i and j enabled cycles respectively. Lane 0 passes through the output register with no extra delay. Skew registers shift only when arr_en=1.
- No arithmetic in the controller: operands and results pass bit-exact, and the controller never truncates. Accumulator overflow is the array's wrap behaviour.
- Reset assertion in any state aborts the job immediately to reset values. A partial result is never presented.

## Timing
- Start accepted at cycle 0. CLEAR is cycle 1, and FEED begins at cycle 2.
- With no stalls: beats occupy cycles 2..K+1, DRAIN occupies K+2..K+7, CAPTURE is K+8, and res_valid first rises at K+9.
- Each FEED stall cycle adds exactly 1 cycle to the total latency.
- arr_en is high for exactly K+6 cycles per job.
- in_ready is combinational from state only, never from in_valid.
- res_valid and res_c do not change until the handshake completes.
- start asserted in the same cycle the done handshake completes is ignored. A new job requires start in IDLE.

## Structure
- Shared package systolic_pkg: the array dimension constant (4), DRAIN_CYCLES=6, the state enumeration (IDLE, CLEAR, FEED, DRAIN, CAPTURE, RESULT), and lane-index helper functions for flat-bus slicing.
- One sub-module: skew_line, parameterised by width and depth (0..3), with an enable-gated shift and an active-low asynchronous reset. It is instantiated 8 times (4 A lanes, 4 B lanes).
- FSM, counters and the result register live in the top module.

## Test plan
- K=1, in_a={1,1,1,1}, in_b={2,2,2,2}, res_ready=1 -> res_valid at cycle 10, all 16 res_c elements = 2, done pulses once.
- K=4, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> res_c equals B row-major; arr_en high for exactly 10 cycles.
- K=4 with in_valid low for 3 cycles between beats 2 and 3 -> identical res_c; res_valid delayed by exactly 3 cycles; arr_en low during the stalls.
- Result backpressure: res_ready low for 5 cycles -> res_valid and res_c stable; start pulses in RESULT are ignored; done on the handshake only.
- cfg_k=0 -> no arr_clr and no arr_en; res_valid with res_c=0 at cycle 1 after start.
- Reset asserted mid-FEED (beat 2 of 4) -> all outputs at reset values immediately. A following K=1 job gives correct results with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and flat-bus lane helpers for the 4x4
// systolic array controller.
package systolic_pkg;

    localparam int unsigned ARR_DIM      = 4;
    localparam int unsigned DRAIN_CYCLES = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        RESULT
    } state_t;

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
        return row * ARR_DIM + col;
    endfunction

endpackage

// File: rtl/systolic_4x4_ctrl_if.sv
// Operand stream and result stream of the systolic array controller.
interface systolic_4x4_ctrl_if #(
    parameter int unsigned data_width = 8,
    parameter int unsigned acc_width  = 2 * data_width
);
    import systolic_pkg::*;

    logic                                     in_valid;
    logic                                     in_ready;
    logic [ARR_DIM*data_width-1:0]            in_a;
    logic [ARR_DIM*data_width-1:0]            in_b;
    logic                                     res_valid;
    logic                                     res_ready;
    logic [ARR_DIM*ARR_DIM*acc_width-1:0]     res_c;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_c
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_c
    );

endinterface

// File: rtl/systolic_4x4_ctrl_skew_line.sv
// Enable-gated delay line used to skew one operand lane into the array.
module skew_line #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    if (depth == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en, clr};
        assign q           = d;
    end else begin : g_shift
        logic [width-1:0] stage [depth];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < depth; s++) stage[s] <= '0;
            end else if (clr) begin
                for (int unsigned s = 0; s < depth; s++) stage[s] <= '0;
            end else if (en) begin
                stage[0] <= d;
                for (int unsigned s = 1; s < depth; s++) stage[s] <= stage[s-1];
            end
        end

        assign q = stage[depth-1];
    end

endmodule

// File: rtl/systolic_4x4_ctrl.sv
// Job sequencer for the 4x4 output-stationary systolic array: clear, skewed
// operand feed, drain, result capture and result handshake.
module systolic_4x4_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned acc_width  = 2 * data_width,
    parameter int unsigned k_width    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [k_width-1:0]                   cfg_k,
    output logic                                 busy,
    output logic                                 done,
    systolic_4x4_ctrl_if.slave                   bus,
    output logic                                 arr_en,
    output logic                                 arr_clr,
    output logic [ARR_DIM*data_width-1:0]        arr_a_flat,
    output logic [ARR_DIM*data_width-1:0]        arr_b_flat,
    input  logic [ARR_DIM*ARR_DIM*acc_width-1:0] arr_c_flat
);

    state_t                               state_q, state_d;
    logic [k_width-1:0]                   k_q;
    logic [k_width-1:0]                   beat_cnt;
    logic [2:0]                           drain_cnt;
    logic                                 beat_acc;
    logic [ARR_DIM*ARR_DIM*acc_width-1:0] res_c_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        arr_en        = 1'b0;
        beat_acc      = 1'b0;
        busy          = (state_q != IDLE);
        bus.in_ready  = (state_q == FEED);
        bus.res_valid = (state_q == RESULT);
        done          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (cfg_k == '0) ? RESULT : CLEAR;
            end
            CLEAR: state_d = FEED;
            FEED: begin
                if (bus.in_valid) begin
                    beat_acc = 1'b1;
                    arr_en   = 1'b1;
                    if (beat_cnt == k_q - k_width'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                arr_en = 1'b1;
                if (drain_cnt == 3'(DRAIN_CYCLES - 1)) state_d = CAPTURE;
            end
            CAPTURE: state_d = RESULT;
            RESULT: begin
                if (bus.res_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            arr_clr   <= 1'b0;
            res_c_q   <= '0;
        end else begin
            arr_clr <= (state_d == CLEAR);
            if (state_q == IDLE && start) begin
                k_q <= cfg_k;
                if (cfg_k == '0) res_c_q <= '0;
            end
            if (state_q == CLEAR)  beat_cnt <= '0;
            else if (beat_acc)     beat_cnt <= beat_cnt + k_width'(1);
            if (state_q == DRAIN)  drain_cnt <= drain_cnt + 3'd1;
            else                   drain_cnt <= '0;
            if (state_q == CAPTURE) res_c_q <= arr_c_flat;
        end
    end

    assign bus.res_c = res_c_q;

    // Lane 0 is combinational so PE(0,0) consumes a beat in its accept cycle;
    // lane i adds i enabled stages, which makes K+6 enables reach PE(3,3).
    for (genvar i = 0; i < ARR_DIM; i++) begin : g_lane
        logic [data_width-1:0] a_d, b_d;

        assign a_d = beat_acc ? bus.in_a[lane_lo(i, data_width) +: data_width] : '0;
        assign b_d = beat_acc ? bus.in_b[lane_lo(i, data_width) +: data_width] : '0;

        skew_line #(.width(data_width), .depth(i)) u_skew_a (
            .clk   (clk),
            .rst_n (rst),
            .en    (arr_en),
            .clr   (arr_clr),
            .d     (a_d),
            .q     (arr_a_flat[lane_lo(i, data_width) +: data_width])
        );

        skew_line #(.width(data_width), .depth(i)) u_skew_b (
            .clk   (clk),
            .rst_n (rst),
            .en    (arr_en),
            .clr   (arr_clr),
            .d     (b_d),
            .q     (arr_b_flat[lane_lo(i, data_width) +: data_width])
        );
    end

endmodule
